// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - segment encodings, display constants and converter state type
package display_pkg;

  localparam int COM_W = 8;

  // Segment order {a,b,c,d,e,f,g,dp}, active-high, a = MSB
  localparam logic [7:0] SEG_0     = 8'b11111100;
  localparam logic [7:0] SEG_1     = 8'b01100000;
  localparam logic [7:0] SEG_2     = 8'b11011010;
  localparam logic [7:0] SEG_3     = 8'b11110010;
  localparam logic [7:0] SEG_4     = 8'b01100110;
  localparam logic [7:0] SEG_5     = 8'b10110110;
  localparam logic [7:0] SEG_6     = 8'b10111110;
  localparam logic [7:0] SEG_7     = 8'b11100000;
  localparam logic [7:0] SEG_8     = 8'b11111110;
  localparam logic [7:0] SEG_9     = 8'b11110110;
  localparam logic [7:0] SEG_A     = 8'b11101110;
  localparam logic [7:0] SEG_B     = 8'b00111110;
  localparam logic [7:0] SEG_C     = 8'b10011100;
  localparam logic [7:0] SEG_D     = 8'b01111010;
  localparam logic [7:0] SEG_E     = 8'b10011110;
  localparam logic [7:0] SEG_F     = 8'b10001110;
  localparam logic [7:0] SEG_BLANK = 8'b00000000;
  localparam logic [7:0] SEG_DASH  = 8'b00000010;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_LOAD,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_t;

  // Letters only appear when hex display is built in; decimal digits never exceed 9
  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      4'd10:   return SEG_A;
      4'd11:   return SEG_B;
      4'd12:   return SEG_C;
      4'd13:   return SEG_D;
      4'd14:   return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter with shadow result (hex bypass: SCAN_DISPLAY_HEX_EN)
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int VALUE_W = 16,
  parameter int DIGITS  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [VALUE_W-1:0]  i_value,
`ifdef SCAN_DISPLAY_HEX_EN
  input  logic                i_hex_mode,
`endif
  output logic                o_done,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic                o_overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  function automatic logic [63:0] ipow(input int base, input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'(base);
    return r;
  endfunction

  localparam logic [63:0] DEC_LIMIT = ipow(10, DIGITS);
`ifdef SCAN_DISPLAY_HEX_EN
  localparam logic [63:0] HEX_LIMIT = ipow(16, DIGITS);
`endif

  conv_state_t        r_state;
  conv_state_t        w_next;
  logic [VALUE_W-1:0] r_bin;
  logic [BCD_W-1:0]   r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;
  logic               r_hex;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               r_done;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_hex_bcd;
  logic [63:0]        w_value_ext;
  logic [63:0]        w_limit;
  logic               w_load_hex;

  assign w_value_ext = {{(64 - VALUE_W){1'b0}}, i_value};
  assign w_hex_bcd   = BCD_W'(r_bin);

`ifdef SCAN_DISPLAY_HEX_EN
  assign w_load_hex = i_hex_mode;
  assign w_limit    = i_hex_mode ? HEX_LIMIT : DEC_LIMIT;
`else
  assign w_load_hex = 1'b0;
  assign w_limit    = DEC_LIMIT;
`endif

  // Add-3 correction on every BCD digit that is 5 or more before the shift
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_work[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
    end
  end

  // Next-state logic: hex loads skip straight to COMMIT
  always_comb begin
    w_next = r_state;
    case (r_state)
      CONV_IDLE:   if (i_start) w_next = CONV_LOAD;
      CONV_LOAD:   w_next = w_load_hex ? CONV_COMMIT : CONV_SHIFT;
      CONV_SHIFT:  if (r_cnt == CNT_W'(VALUE_W - 1)) w_next = CONV_COMMIT;
      CONV_COMMIT: w_next = CONV_IDLE;
      default:     w_next = CONV_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= CONV_IDLE;
    else        r_state <= w_next;
  end

  // Datapath: sample at LOAD, shift VALUE_W times, publish result and overflow together at COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_hex      <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CONV_LOAD: begin
          r_bin      <= i_value;
          r_work     <= '0;
          r_cnt      <= '0;
          r_hex      <= w_load_hex;
          r_ovf_pend <= (w_value_ext >= w_limit);
        end
        CONV_SHIFT: begin
          r_work <= {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
          r_bin  <= r_bin << 1;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        CONV_COMMIT: begin
          r_bcd  <= r_hex ? w_hex_bcd : r_work;
          r_ovf  <= r_ovf_pend;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_done     = r_done;
  assign o_bcd      = r_bcd;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/scan_display_ctrl.sv
// rtl/scan_display_ctrl.sv - multiplexed 7-segment display scanner (optional hex mode: SCAN_DISPLAY_HEX_EN)
module scan_display_ctrl
  import display_pkg::*;
#(
  parameter int VALUE_W  = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [VALUE_W-1:0] value,
  input  logic               blank_lz,
`ifdef SCAN_DISPLAY_HEX_EN
  input  logic               hex_mode,
`endif
  output logic [COM_W-1:0]   seg_COM,
  output logic [7:0]         seg_DATA,
  output logic               conv_done
);

  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0]    r_presc;
  logic [2:0]          r_idx;
  logic [COM_W-1:0]    r_com;
  logic [7:0]          r_data;

  logic [4*DIGITS-1:0] w_shadow;
  logic                w_overflow;
  logic                w_tc;
  logic                w_last_pos;
  logic [3:0]          w_digit;
  logic                w_lead_zero;
  logic [7:0]          w_seg;
  logic [COM_W-1:0]    w_com;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clk        (clk),
    .rst_n      (rst),
    .i_start    (1'b1),
    .i_value    (value),
`ifdef SCAN_DISPLAY_HEX_EN
    .i_hex_mode (hex_mode),
`endif
    .o_done     (conv_done),
    .o_bcd      (w_shadow),
    .o_overflow (w_overflow)
  );

  assign w_tc       = (r_presc == PRE_W'(SCAN_DIV - 1));
  assign w_last_pos = (r_idx == 3'(DIGITS - 1));

  // Prescaler and digit index; disabling parks both at zero so re-enable starts a full hold on position 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (!enable) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_idx   <= w_last_pos ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Select current digit, decide blanking/dash, and build the active-low digit strobe
  always_comb begin
    w_digit     = 4'd0;
    w_lead_zero = (r_idx != 3'd0);
    for (int d = 0; d < DIGITS; d++) begin
      if (r_idx == 3'(d)) w_digit = w_shadow[4*d +: 4];
      if ((3'(d) >= r_idx) && (w_shadow[4*d +: 4] != 4'd0)) w_lead_zero = 1'b0;
    end
    if (w_overflow)                  w_seg = SEG_DASH;
    else if (blank_lz && w_lead_zero) w_seg = SEG_BLANK;
    else                             w_seg = seg_encode(w_digit);
    w_com        = {COM_W{1'b1}};
    w_com[r_idx] = 1'b0;
  end

  // Registered pin drivers; COM and DATA come from the same index and shadow snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_com  <= {COM_W{1'b1}};
      r_data <= SEG_BLANK;
    end else if (!enable) begin
      r_com  <= {COM_W{1'b1}};
      r_data <= SEG_BLANK;
    end else begin
      r_com  <= w_com;
      r_data <= w_seg;
    end
  end

  assign seg_COM  = r_com;
  assign seg_DATA = r_data;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// tb/tb_scan_display_ctrl.sv - self-checking bench for scan_display_ctrl (hex checks with SCAN_DISPLAY_HEX_EN)
module tb_scan_display_ctrl;

  localparam logic [7:0] S0 = 8'b11111100;
  localparam logic [7:0] S1 = 8'b01100000;
  localparam logic [7:0] S2 = 8'b11011010;
  localparam logic [7:0] S3 = 8'b11110010;
  localparam logic [7:0] S4 = 8'b01100110;
  localparam logic [7:0] S5 = 8'b10110110;
  localparam logic [7:0] S6 = 8'b10111110;
  localparam logic [7:0] S7 = 8'b11100000;
  localparam logic [7:0] S8 = 8'b11111110;
  localparam logic [7:0] S9 = 8'b11110110;
  localparam logic [7:0] SB = 8'b00000000;
  localparam logic [7:0] SD = 8'b00000010;
  localparam logic [7:0] SEG_TAB [10] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};

  typedef struct {
    bit          sel;
    logic [15:0] val;
    bit          blz;
    bit          hex;
    int          ndig;
    logic [4:0][7:0] exp;
  } vec_t;

  typedef struct packed {
    logic [7:0] com;
    logic [7:0] data;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        blank_lz;
  logic [15:0] value;
  logic [15:0] value3;
  logic [7:0]  seg_COM, seg_DATA, seg_COM3, seg_DATA3;
  logic        conv_done, conv_done3;
`ifdef SCAN_DISPLAY_HEX_EN
  logic        hex_mode = 1'b0;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  out_t sb[$];

  always #5 clk = ~clk;

  scan_display_ctrl #(.VALUE_W(16), .DIGITS(5), .SCAN_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .value(value), .blank_lz(blank_lz),
`ifdef SCAN_DISPLAY_HEX_EN
    .hex_mode(hex_mode),
`endif
    .seg_COM(seg_COM), .seg_DATA(seg_DATA), .conv_done(conv_done)
  );

  scan_display_ctrl #(.VALUE_W(16), .DIGITS(3), .SCAN_DIV(4)) u_dut3 (
    .clk(clk), .rst(rst), .enable(enable), .value(value3), .blank_lz(blank_lz),
`ifdef SCAN_DISPLAY_HEX_EN
    .hex_mode(hex_mode),
`endif
    .seg_COM(seg_COM3), .seg_DATA(seg_DATA3), .conv_done(conv_done3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit sel, input logic [15:0] val, input bit blz, input bit hex,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input logic [7:0] e4);
    vec_t v;
    v.sel = sel; v.val = val; v.blz = blz; v.hex = hex;
    v.ndig = sel ? 3 : 5;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    return v;
  endfunction

  function automatic int dec_digit(input int v, input int p);
    int x;
    x = v;
    for (int k = 0; k < p; k++) x = x / 10;
    return x % 10;
  endfunction

  // Wait (bounded) for n conversion-done pulses of the chosen instance
  task automatic wait_done(input int n, input bit sel);
    for (int k = 0; k < n; k++) begin
      int  t;
      logic d;
      t = 0;
      d = 1'b0;
      while (!d && t < 80) begin
        @(negedge clk);
        t++;
        d = sel ? conv_done3 : conv_done;
      end
      check("done_seen", {31'd0, d}, 32'd1);
    end
  endtask

  // Decode active position of the 5-digit instance; returns zero count too
  task automatic dec_com(input logic [7:0] c, output int pos, output int zeros);
    pos = -1;
    zeros = 0;
    for (int b = 0; b < 8; b++) if (!c[b]) begin zeros++; pos = b; end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    out_t e, a;
    logic [7:0] c;
    if (v.sel) value3 = v.val; else value = v.val;
    blank_lz = v.blz;
`ifdef SCAN_DISPLAY_HEX_EN
    hex_mode = v.hex;
`endif
    wait_done(2, v.sel);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    a = v.sel ? {seg_COM3, seg_DATA3} : {seg_COM, seg_DATA};
    check($sformatf("v%0d_dark", i), {16'd0, a}, 32'h0000FF00);
    enable = 1'b1;
    for (int pass = 0; pass < 2; pass++)
      for (int p = 0; p < v.ndig; p++)
        for (int k = 0; k < 4; k++) begin
          c = ~(8'h01 << p);
          sb.push_back({c, v.exp[p]});
        end
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      a = v.sel ? {seg_COM3, seg_DATA3} : {seg_COM, seg_DATA};
      check($sformatf("v%0d_out", i), {16'd0, a}, {16'd0, e});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last5, last3, pos, zeros, n, ev;
    logic [7:0] exp_d;

    // Reset and dark display with value present
    rst = 1'b0; enable = 1'b0; blank_lz = 1'b0; value = 16'd123; value3 = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_out5", {15'd0, seg_COM, seg_DATA, conv_done}, {15'd0, 8'hFF, 8'h00, 1'b0});
    check("rst_out3", {15'd0, seg_COM3, seg_DATA3, conv_done3}, {15'd0, 8'hFF, 8'h00, 1'b0});
    rst = 1'b1;
    last5 = -1; last3 = -1;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      check("dark_out", {16'd0, seg_COM, seg_DATA}, 32'h0000FF00);
      if (conv_done) begin
        if (last5 >= 0) check("done_period5", t - last5, 19);
        last5 = t;
      end
      if (conv_done3) begin
        if (last3 >= 0) check("done_period3", t - last3, 19);
        last3 = t;
      end
    end
    check("done_pulsed", {31'd0, (last5 > 0)}, 32'd1);

    // Vector table: {instance, value, blank_lz, hex, expected DATA per position 0..4}
    vecs.push_back(mk(0, 16'd123,   0, 0, S3, S2, S1, S0, S0));
    vecs.push_back(mk(0, 16'd123,   1, 0, S3, S2, S1, SB, SB));
    vecs.push_back(mk(0, 16'd0,     1, 0, S0, SB, SB, SB, SB));
    vecs.push_back(mk(0, 16'd0,     0, 0, S0, S0, S0, S0, S0));
    vecs.push_back(mk(0, 16'd65535, 0, 0, S5, S3, S5, S5, S6));
    vecs.push_back(mk(0, 16'd40960, 1, 0, S0, S6, S9, S0, S4));
    vecs.push_back(mk(1, 16'd1000,  0, 0, SD, SD, SD, SB, SB));
    vecs.push_back(mk(1, 16'd1000,  1, 0, SD, SD, SD, SB, SB));
    vecs.push_back(mk(1, 16'd999,   1, 0, S9, S9, S9, SB, SB));
    vecs.push_back(mk(1, 16'd65535, 0, 0, SD, SD, SD, SB, SB));
    vecs.push_back(mk(1, 16'd7,     1, 0, S7, SB, SB, SB, SB));
`ifdef SCAN_DISPLAY_HEX_EN
    vecs.push_back(mk(0, 16'hBEEF,  0, 1, 8'b10001110, 8'b10011110, 8'b10011110, 8'b00111110, S0));
`endif
    enable = 1'b1;
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);
`ifdef SCAN_DISPLAY_HEX_EN
    hex_mode = 1'b0;
`endif

    // Value change in the middle of SHIFT: old result first, new one on the following commit
    value = 16'd100; blank_lz = 1'b0;
    wait_done(2, 0);
    wait_done(1, 0);
    repeat (3) @(negedge clk);
    value = 16'd200;
    n = 0;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      dec_com(seg_COM, pos, zeros);
      check("mid_com", {30'd0, (zeros == 1), (pos >= 0 && pos < 5)}, 32'd3);
      ev = (n >= 2) ? 200 : 100;
      exp_d = (pos >= 0 && pos < 5) ? SEG_TAB[dec_digit(ev, pos)] : 8'hxx;
      check("mid_data", {24'd0, seg_DATA}, {24'd0, exp_d});
      if (conv_done) begin
        n++;
        if (n == 2) check("new_commit_latency", {31'd0, (t <= 38)}, 32'd1);
      end
    end
    check("mid_commits", {31'd0, (n >= 2)}, 32'd1);

    // Asynchronous reset mid-scan and mid-SHIFT
    value = 16'd123;
    wait_done(2, 0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst", {15'd0, seg_COM, seg_DATA, conv_done}, {15'd0, 8'hFF, 8'h00, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int t = 1; t <= 45 && n == 0; t++) begin
      @(negedge clk);
      dec_com(seg_COM, pos, zeros);
      check("post_rst_com", {30'd0, (zeros == 1), (pos >= 0 && pos < 5)}, 32'd3);
      check("post_rst_zero", {24'd0, seg_DATA}, {24'd0, S0});
      if (conv_done) n++;
    end
    check("post_rst_done", n, 1);
    @(negedge clk);
    dec_com(seg_COM, pos, zeros);
    exp_d = (pos >= 0 && pos < 5) ? SEG_TAB[dec_digit(123, pos)] : 8'hxx;
    check("post_rst_new", {24'd0, seg_DATA}, {24'd0, exp_d});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
